// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the S3 bit-chain datapaths.
// Holds default widths and the single-bit borrow cell.
package arith_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_SLICE = 8;

    typedef struct packed {
        logic bo;
        logic d;
    } sub_res_t;

    function automatic sub_res_t sub_bit(
        input logic a,
        input logic b,
        input logic bi
    );
        sub_res_t r;
        r.d  = a ^ b ^ bi;
        r.bo = (~a & b) | (~a & bi) | (b & bi);
        return r;
    endfunction

endpackage

// File: rtl/rbs_32bit_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// master = operand source / result consumer, slave = subtractor.
interface rbs_32bit_pipe_if
    import arith_pkg::*;
#(
    parameter int N = DEF_N
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] input_a;
    logic [N-1:0] input_b;
    logic         borrowin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrowout;
    logic         overflow;

    modport master (
        output in_valid,
        output input_a,
        output input_b,
        output borrowin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrowout,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  input_a,
        input  input_b,
        input  borrowin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrowout,
        output overflow
    );

endinterface

// File: rtl/rbs_slice.sv
// Combinational SLICE-bit ripple-borrow chain.
// One instance per pipeline stage of rbs_32bit_pipe.
module rbs_slice
    import arith_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bi,
    output logic [SLICE-1:0] d,
    output logic             bo
);

    always_comb begin
        sub_res_t r;
        logic     br;
        d  = '0;
        br = bi;
        for (int i = 0; i < SLICE; i++) begin
            r    = sub_bit(a[i], b[i], br);
            d[i] = r.d;
            br   = r.bo;
        end
        bo = br;
    end

endmodule

// File: rtl/rbs_32bit_pipe.sv
// Pipelined ripple-borrow subtractor, SLICE bits resolved per stage.
// Stage registers carry partial diff, operands, borrow and sign info.
module rbs_32bit_pipe
    import arith_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                clk,
    input  logic                rst_n,
    rbs_32bit_pipe_if.slave     bus
);

    localparam int STAGES = N / SLICE;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [N-1:0]      diff_q [STAGES];
    logic [N-1:0]      diff_d [STAGES];
    logic [N-1:0]      a_q    [STAGES];
    logic [N-1:0]      a_d    [STAGES];
    logic [N-1:0]      b_q    [STAGES];
    logic [N-1:0]      b_d    [STAGES];
    logic [STAGES-1:0] bor_q;
    logic [STAGES-1:0] bor_d;
    logic [STAGES-1:0] amsb_q;
    logic [STAGES-1:0] amsb_d;
    logic [STAGES-1:0] sgn_q;
    logic [STAGES-1:0] sgn_d;

    logic [STAGES-1:0] adv;
    logic              accept;

    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_bi;
    logic [STAGES-1:0] up_amsb;
    logic [STAGES-1:0] up_sgn;
    logic [N-1:0]      up_a    [STAGES];
    logic [N-1:0]      up_b    [STAGES];
    logic [N-1:0]      up_diff [STAGES];
    logic [N-1:0]      st_diff [STAGES];
    logic [SLICE-1:0]  sl_d    [STAGES];
    logic [STAGES-1:0] sl_bo;
    logic [STAGES-1:0] unused_ab;

    // Advance ripples back from the output so bubbles collapse under stall.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = !v_q[STAGES-1] || bus.out_ready;
        adv[STAGES-1] = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt    = !v_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    assign bus.in_ready = adv[0];
    assign accept       = bus.in_valid && adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [N-1:0] MSK =
            {{(N-SLICE){1'b0}}, {SLICE{1'b1}}} << (k * SLICE);

        if (k == 0) begin : g_head
            assign up_v[k]    = accept;
            assign up_a[k]    = bus.input_a;
            assign up_b[k]    = bus.input_b;
            assign up_bi[k]   = bus.borrowin;
            assign up_amsb[k] = bus.input_a[N-1];
            assign up_sgn[k]  = bus.input_a[N-1] ^ bus.input_b[N-1];
            assign up_diff[k] = '0;
        end else begin : g_body
            assign up_v[k]    = v_q[k-1];
            assign up_a[k]    = a_q[k-1];
            assign up_b[k]    = b_q[k-1];
            assign up_bi[k]   = bor_q[k-1];
            assign up_amsb[k] = amsb_q[k-1];
            assign up_sgn[k]  = sgn_q[k-1];
            assign up_diff[k] = diff_q[k-1];
        end

        rbs_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a  (up_a[k][k*SLICE +: SLICE]),
            .b  (up_b[k][k*SLICE +: SLICE]),
            .bi (up_bi[k]),
            .d  (sl_d[k]),
            .bo (sl_bo[k])
        );

        assign st_diff[k] = (up_diff[k] & ~MSK)
                          | ({{(N-SLICE){1'b0}}, sl_d[k]} << (k * SLICE));

        // Operand bits below the current slice are dead once resolved.
        assign unused_ab[k] = ^{a_q[k], b_q[k]};
    end

    always_comb begin
        v_d    = v_q;
        diff_d = diff_q;
        a_d    = a_q;
        b_d    = b_q;
        bor_d  = bor_q;
        amsb_d = amsb_q;
        sgn_d  = sgn_q;
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    diff_d[k] = st_diff[k];
                    a_d[k]    = up_a[k];
                    b_d[k]    = up_b[k];
                    bor_d[k]  = sl_bo[k];
                    amsb_d[k] = up_amsb[k];
                    sgn_d[k]  = up_sgn[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            bor_q  <= '0;
            amsb_q <= '0;
            sgn_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                diff_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
            end
        end else begin
            v_q    <= v_d;
            diff_q <= diff_d;
            a_q    <= a_d;
            b_q    <= b_d;
            bor_q  <= bor_d;
            amsb_q <= amsb_d;
            sgn_q  <= sgn_d;
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.diff      = diff_q[STAGES-1];
    assign bus.borrowout = bor_q[STAGES-1];
    assign bus.overflow  = sgn_q[STAGES-1]
                        && (diff_q[STAGES-1][N-1] != amsb_q[STAGES-1]);

endmodule
